// File: rtl/verin_pkg.sv
// Shared types and constants for the cylinder H-bridge PWM driver.
package verin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int DEAD_CYCLES_DEF = 1000;
  localparam int MIN_PERIOD      = 2;

endpackage

// File: rtl/verin_pwm_counter.sv
// Period counter with boundary-synchronous period/duty latches and registered PWM compare.
module verin_pwm_counter
  import verin_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm,
  output logic             tick
);

  localparam logic [CNT_W-1:0] STEP      = 1;
  localparam logic [CNT_W:0]   STEP_WIDE = 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_l;
  logic [CNT_W-1:0] duty_l;
  logic             wrap;

  // Widened compare so a period_l of 0 cannot underflow into a huge terminal count.
  assign wrap = ({1'b0, cnt} + STEP_WIDE) >= {1'b0, period_l};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      period_l <= '0;
      duty_l   <= '0;
      pwm      <= 1'b0;
      tick     <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      period_l <= period;
      duty_l   <= duty;
      pwm      <= 1'b0;
      tick     <= 1'b0;
    end else if (run) begin
      pwm  <= (cnt < duty_l);
      tick <= wrap;
      if (wrap) begin
        cnt      <= '0;
        period_l <= period;
        duty_l   <= duty;
      end else begin
        cnt <= cnt + STEP;
      end
    end else begin
      pwm  <= 1'b0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/verin_pwm_driver.sv
// H-bridge drive: PWM plus direction line, with a forced-low dead time on every reversal.
module verin_pwm_driver
  import verin_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sens_in,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out,
  output logic             sens_out,
  output logic             busy,
  output logic             period_tick
);

  localparam int               DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_STEP = 1;
  localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(MIN_PERIOD);

  state_t           state;
  state_t           next;
  logic [DEAD_W-1:0] dead_cnt;
  logic             period_ok;
  logic             dead_done;
  logic             clear;
  logic             run;
  logic             load_dead;
  logic             latch_sens;

  assign period_ok = enable && (period >= MIN_P);
  assign dead_done = (dead_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (period_ok) next = (sens_in == sens_out) ? RUN : DEAD;
      RUN: begin
        if (!enable)                next = IDLE;
        else if (sens_in != sens_out) next = DEAD;
      end
      DEAD: if (dead_done) next = period_ok ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  // The counter only free-runs while RUN persists; any exit forces PWM low on the same edge.
  always_comb begin
    busy       = (state == DEAD);
    clear      = (next == RUN) && (state != RUN);
    run        = (state == RUN) && (next == RUN);
    load_dead  = (next == DEAD) && (state != DEAD);
    latch_sens = (state == DEAD) && dead_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dead_cnt <= '0;
      sens_out <= 1'b0;
    end else begin
      if (load_dead)
        dead_cnt <= DEAD_LOAD;
      else if ((state == DEAD) && !dead_done)
        dead_cnt <= dead_cnt - DEAD_STEP;
      if (latch_sens)
        sens_out <= sens_in;
    end
  end

  verin_pwm_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .run    (run),
    .period (period),
    .duty   (duty),
    .pwm    (pwm_out),
    .tick   (period_tick)
  );

endmodule

// File: tb/tb_verin_pwm_driver.sv
// Scoreboard bench for verin_pwm_driver: directed vectors push expected per-cycle outputs, a monitor pops and compares.
module tb_verin_pwm_driver;

  localparam int CNT_W = 8;
  localparam int DEAD  = 4;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             enable  = 1'b0;
  logic             sens_in = 1'b0;
  logic [CNT_W-1:0] period  = '0;
  logic [CNT_W-1:0] duty    = '0;
  logic             pwm_out;
  logic             sens_out;
  logic             busy;
  logic             period_tick;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   zero_run  = 0;
  logic prev_sens = 1'b0;

  verin_pwm_driver #(
    .CNT_W       (CNT_W),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sens_in     (sens_in),
    .period      (period),
    .duty        (duty),
    .pwm_out     (pwm_out),
    .sens_out    (sens_out),
    .busy        (busy),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Vector layout everywhere: {pwm_out, sens_out, busy, period_tick}
  function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {pwm,sens,busy,tick}=%b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic push(string tag, logic p, logic s, logic b, logic t);
    exp_t e;
    e.exp = {p, s, b, t};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_n(string tag, int n, logic p, logic s, logic b);
    for (int i = 0; i < n; i++) push(tag, p, s, b, 1'b0);
  endtask

  // One PWM period: 'hi' cycles high then low, tick on the wrap cycle.
  task automatic push_period(string tag, int per, int hi, logic s);
    for (int c = 0; c < per; c++) push(tag, (c < hi), s, 1'b0, (c == per - 1));
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [3:0] s;
    exp_t       e;
    #1;
    s = {pwm_out, sens_out, busy, period_tick};
    if (reset) begin
      prev_sens = 1'b0;
      zero_run  = 0;
    end else begin
      if (sens_out != prev_sens) begin
        check("dead_gap", (zero_run >= DEAD) ? 4'b0001 : 4'b0000, 4'b0001);
        check("edge_pwm_low", {3'b000, pwm_out}, 4'b0000);
      end
      prev_sens = sens_out;
      zero_run  = pwm_out ? 0 : zero_run + 1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, s, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b1;
    #1 check("reset", {pwm_out, sens_out, busy, period_tick}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    push_n("idle", 2, 1'b0, 1'b0, 1'b0);
    step(2);

    // Basic 3/7 waveform
    enable = 1'b1; sens_in = 1'b0; period = 8'd10; duty = 8'd3;
    push("t1_start", 1'b0, 1'b0, 1'b0, 1'b0);
    push_period("t1", 10, 3, 1'b0);
    step(11);

    // Duty change mid-period only lands at the boundary
    push_period("t2_old", 10, 3, 1'b0);
    step(3);
    duty = 8'd7;
    step(7);
    push_period("t2_new", 10, 7, 1'b0);
    step(10);

    // Reversal while PWM is high; sens_in wobbles during the dead time
    push_n("t3_run", 2, 1'b1, 1'b0, 1'b0);
    step(2);
    sens_in = 1'b1;
    push_n("t3_dead", 4, 1'b0, 1'b0, 1'b1);
    step(1);
    sens_in = 1'b0;
    step(1);
    sens_in = 1'b1;
    step(2);
    push("t3_restart", 1'b0, 1'b1, 1'b0, 1'b0);
    push_period("t3_run2", 10, 7, 1'b1);
    step(11);

    // Direction taken from sens_in on the last dead cycle, not at entry
    push_n("t4_run", 2, 1'b1, 1'b1, 1'b0);
    step(2);
    sens_in = 1'b0;
    push_n("t4_dead", 4, 1'b0, 1'b1, 1'b1);
    step(4);
    sens_in = 1'b1;
    push("t4_restart", 1'b0, 1'b1, 1'b0, 1'b0);
    push_period("t4_run2", 10, 7, 1'b1);
    step(11);

    // Duty extremes, enable drop, period below minimum
    duty = 8'd0;
    push_period("t5_prev", 10, 7, 1'b1);
    step(10);
    duty = 8'd12;
    push_period("t5_zero", 10, 0, 1'b1);
    step(10);
    push_period("t5_full", 10, 10, 1'b1);
    step(10);
    enable = 1'b0;
    push("t5_stop", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    period = 8'd1; enable = 1'b1;
    push_n("t5_per1", 3, 1'b0, 1'b1, 1'b0);
    step(3);

    // Asynchronous reset in RUN
    period = 8'd10; duty = 8'd5;
    push("t6_start", 1'b0, 1'b1, 1'b0, 1'b0);
    push_n("t6_run", 3, 1'b1, 1'b1, 1'b0);
    step(4);
    reset = 1'b1;
    #1 check("t6_rst_run", {pwm_out, sens_out, busy, period_tick}, 4'b0000);
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    push_n("t6_idle", 2, 1'b0, 1'b0, 1'b0);
    step(2);

    // Asynchronous reset in DEAD (sens_in=1 vs sens_out=0 enters DEAD from IDLE)
    enable = 1'b1;
    push_n("t6_dead", 2, 1'b0, 1'b0, 1'b1);
    step(2);
    reset = 1'b1;
    #1 check("t6_rst_dead", {pwm_out, sens_out, busy, period_tick}, 4'b0000);
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    push_n("t6_idle2", 3, 1'b0, 1'b0, 1'b0);
    step(3);
    enable = 1'b1; sens_in = 1'b0;
    push("t6_resume", 1'b0, 1'b0, 1'b0, 1'b0);
    push_n("t6_resume_run", 2, 1'b1, 1'b0, 1'b0);
    step(3);

    step(2);
    check("sb_drain", (sb.size() == 0) ? 4'b0001 : 4'b0000, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
